// File: rtl/sram_mem_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_mem_controller_pkg
//
// Shared definitions for the MEM-stage SRAM controller and its phase timer.
//   state_e          : controller FSM states (IDLE / LOW / HIGH / DONE)
//   SRAM_AW_DEFAULT  : default SRAM half-word address width
//   DQ_W             : width of the external SRAM data bus
// -----------------------------------------------------------------------------
package sram_mem_controller_pkg;

    localparam int SRAM_AW_DEFAULT = 18;
    localparam int DQ_W            = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// -----------------------------------------------------------------------------
// sram_phase_timer
//
// Counts the cycles of one half-word phase on the SRAM bus. The count is held
// at zero while start_i is high, then advances once per cycle and wraps back
// to zero after its last cycle, so consecutive phases line up without any
// extra control from the FSM.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   start_i  : hold the count at zero (controller not in a bus phase)
//   last_o   : current cycle is the last cycle of the phase
// -----------------------------------------------------------------------------
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic last_o
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last_o = (count_q == CW'(WAIT_CYCLES - 1));

    // Wrap on the last cycle so the next phase starts at zero automatically.
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (last_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// Multi-cycle bridge between the MEM stage and a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half-word accesses (low half first).
// While an access is under way the whole pipeline is frozen; completion is
// signalled by a one-cycle ready pulse, during which freeze is low so the
// pipeline advances and MEM/WB captures rdata.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   rd_en, wr_en  : load / store request from EXE/MEM (both high = store)
//   addr          : byte address; word index = addr[SRAM_AW:2]
//   wdata         : store data
//   rdata         : load word, valid while ready=1, then held
//   ready         : one-cycle completion pulse
//   freeze        : combinational pipeline stall request
//   sram_addr     : SRAM half-word address
//   sram_dq_out   : SRAM write data
//   sram_dq_oe    : 1 = controller drives the DQ bus
//   sram_dq_in    : SRAM read data
//   sram_we_n     : SRAM write enable, active low
// -----------------------------------------------------------------------------
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = SRAM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DQ_W-1:0]    sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [DQ_W-1:0]    sram_dq_in,
    output logic               sram_we_n
);

    localparam int IW = SRAM_AW - 1;

    state_e            state_q;
    state_e            state_d;
    logic [IW-1:0]     wordIdx_q;
    logic [31:0]       wdata_q;
    logic              isWrite_q;
    logic [31:0]       rdata_q;

    logic              request;
    logic              inPhase;
    logic              phaseLast;
    logic              weActive;
    logic              unusedAddrBits;

    assign request = rd_en | wr_en;
    assign inPhase = (state_q == LOW) || (state_q == HIGH);

    // Byte-lane bits and address bits above the SRAM range are ignored,
    // which makes larger addresses wrap onto the SRAM.
    assign unusedAddrBits = ^{addr[31:SRAM_AW+1], addr[1:0]};

    // The final cycle of a write phase deasserts we_n while data is still
    // driven, giving the SRAM a data-hold cycle. A single-cycle phase has no
    // room for that, so we_n stays low for it.
    assign weActive = (WAIT_CYCLES == 1) || !phaseLast;

    sram_phase_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (!inPhase),
        .last_o  (phaseLast)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Once an access leaves IDLE it always runs to DONE,
    // even if the request is withdrawn, so a store is never left half-written.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (request)   state_d = LOW;
            LOW:  if (phaseLast) state_d = HIGH;
            HIGH: if (phaseLast) state_d = DONE;
            DONE:                state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Operand latch and read-data capture. Operands are taken only when an
    // access starts, so the pipeline inputs may change freely afterwards.
    // Each read half is captured on the last cycle of its phase, when the
    // SRAM has had the full wait time to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wordIdx_q <= '0;
            wdata_q   <= '0;
            isWrite_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (state_q == IDLE && request) begin
                wordIdx_q <= addr[SRAM_AW:2];
                wdata_q   <= wdata;
                isWrite_q <= wr_en;
            end
            if (!isWrite_q && phaseLast) begin
                if (state_q == LOW) begin
                    rdata_q[15:0] <= sram_dq_in;
                end else if (state_q == HIGH) begin
                    rdata_q[31:16] <= sram_dq_in;
                end
            end
        end
    end

    // Output decode. freeze is combinational so a new request stalls the
    // pipeline in the same cycle it appears.
    always_comb begin
        freeze      = 1'b0;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (state_q)
            IDLE: begin
                freeze = request;
            end
            LOW: begin
                freeze    = 1'b1;
                sram_addr = {wordIdx_q, 1'b0};
                if (isWrite_q) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = !weActive;
                end
            end
            HIGH: begin
                freeze    = 1'b1;
                sram_addr = {wordIdx_q, 1'b1};
                if (isWrite_q) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = !weActive;
                end
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                freeze = 1'b0;
            end
        endcase
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Self-checking bench for sram_mem_controller. A behavioural SRAM (sparse
// half-word array) answers the controller's bus, and a word-level reference
// memory predicts load results, cycle timing and bus activity for directed
// and randomized accesses.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdEn = 1'b0;
    logic          wrEn = 1'b0;
    logic [31:0]   addrIn = '0;
    logic [31:0]   wdataIn = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic          freeze;
    logic [AW-1:0] sramAddr;
    logic [15:0]   sramDqOut;
    logic          sramDqOe;
    logic [15:0]   sramDqIn = '0;
    logic          sramWeN;

    int            checks = 0;
    int            errors = 0;
    int            cycleCount = 0;
    int            lastReadyCycle = -1;
    logic [31:0]   lastRead = '0;

    logic [15:0]   sramMem [int];
    logic [31:0]   refWord [int];

    sram_mem_controller #(
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rdEn),
        .wr_en       (wrEn),
        .addr        (addrIn),
        .wdata       (wdataIn),
        .rdata       (rdata),
        .ready       (ready),
        .freeze      (freeze),
        .sram_addr   (sramAddr),
        .sram_dq_out (sramDqOut),
        .sram_dq_oe  (sramDqOe),
        .sram_dq_in  (sramDqIn),
        .sram_we_n   (sramWeN)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Contents of SRAM locations never written by the controller.
    function automatic logic [15:0] initHalf(input int a);
        return 16'(a * 40503 + 4660);
    endfunction

    function automatic logic [15:0] sramLookup(input int a);
        if (sramMem.exists(a)) return sramMem[a];
        return initHalf(a);
    endfunction

    function automatic int wordIdx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << (AW - 1)) - 32'd1));
    endfunction

    function automatic logic [31:0] refRead(input int i);
        if (refWord.exists(i)) return refWord[i];
        return {initHalf(2 * i + 1), initHalf(2 * i)};
    endfunction

    // Behavioural asynchronous SRAM, evaluated mid-cycle when the bus is stable.
    always @(negedge clk) begin
        if (!rst && sramDqOe && !sramWeN) sramMem[int'(sramAddr)] = sramDqOut;
        sramDqIn <= sramLookup(int'(sramAddr));
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Runs one access starting in the current cycle (called just after a
    // rising edge) and checks every cycle against the expected timeline:
    // cycle 0 request, cycles 1..W low half, W+1..2W high half, 2W+1 ready.
    // Inputs at or after dropCycle are withdrawn; otherwise addr/wdata are
    // scrambled after cycle 0 to show the operands were latched.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input int dropCycle);
        logic        isWr;
        int          idx;
        int          phase;
        int          pos;
        int          doneCyc;
        logic [31:0] expRdata;
        isWr    = wr;
        idx     = wordIdx(a);
        doneCyc = 2 * W + 1;
        expRdata = isWr ? lastRead : refRead(idx);
        lastReadyCycle = -1;
        rdEn    = rd;
        wrEn    = wr;
        addrIn  = a;
        wdataIn = d;
        for (int c = 0; c <= doneCyc; c++) begin
            @(negedge clk);
            checkOutput("freeze", 32'(freeze), (c <= 2 * W) ? 32'd1 : 32'd0);
            checkOutput("ready", 32'(ready), (c == doneCyc) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 2 * W) begin
                phase = (c - 1) / W;
                pos   = (c - 1) % W;
                checkOutput("sram_addr", 32'(sramAddr), 32'((2 * idx + phase) % (1 << AW)));
                checkOutput("dq_oe", 32'(sramDqOe), 32'(isWr));
                checkOutput("we_n", 32'(sramWeN),
                            (isWr && (pos < W - 1 || W == 1)) ? 32'd0 : 32'd1);
                if (isWr) checkOutput("dq_out", 32'(sramDqOut), phase == 1 ? 32'(d[31:16]) : 32'(d[15:0]));
            end else begin
                checkOutput("idle_oe", 32'(sramDqOe), 32'd0);
                checkOutput("idle_we_n", 32'(sramWeN), 32'd1);
            end
            if (c == doneCyc) begin
                checkOutput("rdata", rdata, expRdata);
                if (ready) lastReadyCycle = cycleCount;
            end
            @(posedge clk);
            #1;
            if (c + 1 >= dropCycle) begin
                rdEn = 1'b0;
                wrEn = 1'b0;
            end
            addrIn  = $urandom;
            wdataIn = $urandom;
        end
        rdEn = 1'b0;
        wrEn = 1'b0;
        if (isWr) begin
            refWord[idx] = d;
            checkOutput("mem_lo", 32'(sramLookup(2 * idx)), 32'(d[15:0]));
            checkOutput("mem_hi", 32'(sramLookup(2 * idx + 1)), 32'(d[31:16]));
        end else begin
            lastRead = expRdata;
        end
    endtask

    int           t1;
    int           op;
    int           drop;
    int           gap;
    logic [31:0]  ra;
    logic [31:0]  rd32;

    initial begin
        sramMem[8]  = 16'hBEEF;
        sramMem[9]  = 16'hDEAD;
        refWord[4]  = 32'hDEADBEEF;

        // Reset state
        #2;
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_addr", 32'(sramAddr), 32'd0);
        checkOutput("rst_oe", 32'(sramDqOe), 32'd0);
        checkOutput("rst_we_n", 32'(sramWeN), 32'd1);
        checkOutput("rst_freeze0", 32'(freeze), 32'd0);
        rdEn = 1'b1;
        #1;
        checkOutput("rst_freeze1", 32'(freeze), 32'd1);
        rdEn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed read of word 4
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 99);
        checkOutput("read_word", rdata, 32'hDEADBEEF);

        // Directed write
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678, 99);

        // Back-to-back write then read
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 99);
        t1 = lastReadyCycle;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 99);
        checkOutput("b2b_gap", 32'(lastReadyCycle - t1), 32'(2 * W + 2));
        checkOutput("b2b_rdata", rdata, 32'hCAFEF00D);

        // Flush: request dropped in cycle 2
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 2);
        @(negedge clk);
        checkOutput("flush_idle_freeze", 32'(freeze), 32'd0);
        checkOutput("flush_idle_ready", 32'(ready), 32'd0);
        checkOutput("flush_idle_addr", 32'(sramAddr), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset during the high-half write phase
        wrEn    = 1'b1;
        addrIn  = 32'h80;
        wdataIn = 32'h55AA33CC;
        repeat (W + 1) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_we_n", 32'(sramWeN), 32'd1);
        checkOutput("arst_oe", 32'(sramDqOe), 32'd0);
        checkOutput("arst_ready", 32'(ready), 32'd0);
        checkOutput("arst_addr", 32'(sramAddr), 32'd0);
        checkOutput("arst_freeze", 32'(freeze), 32'd1);
        checkOutput("arst_rdata", rdata, 32'd0);
        lastRead = '0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        wrEn = 1'b0;
        @(negedge clk);
        checkOutput("arst_idle_freeze", 32'(freeze), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h0BADF00D, 99);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 99);
        checkOutput("arst_readback", rdata, 32'h0BADF00D);

        // Simultaneous rd_en/wr_en behaves as a store
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h77778888, 99);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 99);
        checkOutput("both_readback", rdata, 32'h77778888);

        // Randomized accesses over a few words, with wrapped upper address bits
        for (int n = 0; n < 24; n++) begin
            op   = int'($urandom_range(0, 2));
            ra   = ($urandom & 32'hFFF80000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
            rd32 = $urandom;
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * W)) : 99;
            applyStimulus(op != 1, op != 0, ra, rd32, drop);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkOutput("gap_freeze", 32'(freeze), 32'd0);
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
